// File: rtl/spy_ctl_pkg.sv
// Shared definitions for the spy-bus register bank and run/step controller:
// register addresses, MODE/STATUS bit positions and controller state encoding.
package spy_ctl_pkg;

  localparam logic [3:0] SPY_ADDR_IR0     = 4'd0;
  localparam logic [3:0] SPY_ADDR_IR1     = 4'd1;
  localparam logic [3:0] SPY_ADDR_IR2     = 4'd2;
  localparam logic [3:0] SPY_ADDR_MODE    = 4'd3;
  localparam logic [3:0] SPY_ADDR_PC      = 4'd4;
  localparam logic [3:0] SPY_ADDR_STATUS  = 4'd5;
  localparam logic [3:0] SPY_ADDR_SCRATCH = 4'd6;
  localparam logic [3:0] SPY_ADDR_STEPCNT = 4'd7;

  localparam int unsigned MODE_RUN  = 0;
  localparam int unsigned MODE_STEP = 1;

  localparam int unsigned STATUS_RUNNING  = 0;
  localparam int unsigned STATUS_STEPPING = 1;
  localparam int unsigned STATUS_ERR      = 2;
  localparam int unsigned STATUS_READY    = 3;

  typedef enum logic [1:0] {
    ST_HALT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP      = 2'd2,
    ST_STEP_WAIT = 2'd3
  } step_state_e;

endpackage

// File: rtl/spy_ctl_step_fsm.sv
// CPU run/halt/step sequencer: free-run enable, N-step single-stepping with a
// remaining-step counter, and error-driven halt.
module spy_step_fsm
  import spy_ctl_pkg::*;
#(
  parameter int unsigned STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_wr_i,
  input  logic              wr_run_i,
  input  logic              wr_step_i,
  input  logic [STEP_W-1:0] stepcnt_i,
  input  logic              cpu_ready_i,
  input  logic              cpu_err_i,
  output logic              cpu_run_o,
  output logic              cpu_step_o,
  output logic              running_o,
  output logic              stepping_o,
  output logic              err_set_o,
  output logic              clr_run_o,
  output logic              clr_step_o
);

  localparam logic [STEP_W-1:0] ONE = STEP_W'(1);

  step_state_e       state_q, state_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic              err_q;
  logic              err_rise;

  assign err_rise = cpu_err_i & ~err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HALT;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      err_q       <= cpu_err_i;
    end
  end

  // Error beats any simultaneous MODE write; RUN beats STEP.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cpu_step_o  = 1'b0;
    err_set_o   = 1'b0;
    clr_run_o   = 1'b0;
    clr_step_o  = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (mode_wr_i && wr_run_i) begin
          state_d = ST_RUN;
        end else if (mode_wr_i && wr_step_i) begin
          state_d     = ST_STEP;
          remaining_d = (stepcnt_i == '0) ? ONE : stepcnt_i;
        end
      end
      ST_RUN: begin
        if (err_rise) begin
          state_d   = ST_HALT;
          err_set_o = 1'b1;
          clr_run_o = 1'b1;
        end else if (mode_wr_i && !wr_run_i) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP, ST_STEP_WAIT: begin
        if (cpu_err_i) begin
          state_d     = ST_HALT;
          err_set_o   = 1'b1;
          clr_step_o  = 1'b1;
          remaining_d = '0;
        end else if (mode_wr_i && wr_run_i) begin
          state_d     = ST_RUN;
          remaining_d = '0;
        end else if (mode_wr_i && !wr_step_i) begin
          state_d     = ST_HALT;
          remaining_d = '0;
        end else if (state_q == ST_STEP) begin
          if (cpu_ready_i) begin
            cpu_step_o  = 1'b1;
            remaining_d = remaining_q - ONE;
            state_d     = ST_STEP_WAIT;
          end
        end else if (remaining_q == '0) begin
          state_d    = ST_HALT;
          clr_step_o = 1'b1;
        end else begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  assign cpu_run_o  = (state_q == ST_RUN);
  assign running_o  = (state_q == ST_RUN);
  assign stepping_o = (state_q == ST_STEP) || (state_q == ST_STEP_WAIT);

endmodule

// File: rtl/spy_ctl.sv
// Spy-bus register bank: strobe decode, MODE/STATUS/SCRATCH/STEPCNT registers,
// IR/PC snapshot shadows and readback mux; run/step sequencing in spy_step_fsm.
module spy_ctl
  import spy_ctl_pkg::*;
#(
  parameter int unsigned PC_W   = 14,
  parameter int unsigned STEP_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dbread,
  input  logic            dbwrite,
  input  logic [3:0]      eadr,
  input  logic [15:0]     spy_out,
  output logic [15:0]     spy_in,
  input  logic [47:0]     cpu_ir,
  input  logic [PC_W-1:0] cpu_pc,
  input  logic            cpu_ready,
  input  logic            cpu_err,
  output logic            cpu_run,
  output logic            cpu_step
);

  logic [15:0]       mode_q, mode_d;
  logic [15:0]       scratch_q, scratch_d;
  logic [STEP_W-1:0] stepcnt_q, stepcnt_d;
  logic              err_latched_q, err_latched_d;
  logic [31:0]       shadow_ir_q;
  logic [PC_W-1:0]   shadow_pc_q;

  logic wr_mode, wr_status, wr_scratch, wr_stepcnt, snap;
  logic running, stepping, err_set, clr_run, clr_step;
  logic [15:0] rdata;

  assign wr_mode    = dbwrite && (eadr == SPY_ADDR_MODE);
  assign wr_status  = dbwrite && (eadr == SPY_ADDR_STATUS);
  assign wr_scratch = dbwrite && (eadr == SPY_ADDR_SCRATCH);
  assign wr_stepcnt = dbwrite && (eadr == SPY_ADDR_STEPCNT);
  assign snap       = dbread  && (eadr == SPY_ADDR_IR0);

  spy_step_fsm #(
    .STEP_W (STEP_W)
  ) u_step_fsm (
    .clk         (clk),
    .reset       (reset),
    .mode_wr_i   (wr_mode),
    .wr_run_i    (spy_out[MODE_RUN]),
    .wr_step_i   (spy_out[MODE_STEP]),
    .stepcnt_i   (stepcnt_q),
    .cpu_ready_i (cpu_ready),
    .cpu_err_i   (cpu_err),
    .cpu_run_o   (cpu_run),
    .cpu_step_o  (cpu_step),
    .running_o   (running),
    .stepping_o  (stepping),
    .err_set_o   (err_set),
    .clr_run_o   (clr_run),
    .clr_step_o  (clr_step)
  );

  // Controller-driven clears are applied after the write so they take effect.
  always_comb begin
    mode_d = mode_q;
    if (wr_mode) mode_d = spy_out;
    if (clr_run) mode_d[MODE_RUN] = 1'b0;
    if (clr_step) mode_d[MODE_STEP] = 1'b0;

    scratch_d = wr_scratch ? spy_out : scratch_q;
    stepcnt_d = wr_stepcnt ? spy_out[STEP_W-1:0] : stepcnt_q;

    err_latched_d = err_latched_q;
    if (err_set) err_latched_d = 1'b1;
    else if (wr_status && spy_out[STATUS_ERR]) err_latched_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= '0;
      scratch_q     <= '0;
      stepcnt_q     <= STEP_W'(1);
      err_latched_q <= 1'b0;
      shadow_ir_q   <= '0;
      shadow_pc_q   <= '0;
    end else begin
      mode_q        <= mode_d;
      scratch_q     <= scratch_d;
      stepcnt_q     <= stepcnt_d;
      err_latched_q <= err_latched_d;
      if (snap) begin
        shadow_ir_q <= cpu_ir[47:16];
        shadow_pc_q <= cpu_pc;
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (eadr)
      SPY_ADDR_IR0:     rdata = cpu_ir[15:0];
      SPY_ADDR_IR1:     rdata = shadow_ir_q[15:0];
      SPY_ADDR_IR2:     rdata = shadow_ir_q[31:16];
      SPY_ADDR_MODE:    rdata = mode_q;
      SPY_ADDR_PC:      rdata[PC_W-1:0] = shadow_pc_q;
      SPY_ADDR_STATUS: begin
        rdata[STATUS_RUNNING]  = running;
        rdata[STATUS_STEPPING] = stepping;
        rdata[STATUS_ERR]      = err_latched_q;
        rdata[STATUS_READY]    = cpu_ready;
      end
      SPY_ADDR_SCRATCH: rdata = scratch_q;
      SPY_ADDR_STEPCNT: rdata[STEP_W-1:0] = stepcnt_q;
      default:          rdata = '0;
    endcase
  end

  assign spy_in = (dbread && !reset) ? rdata : '0;

endmodule

// File: tb/tb_spy_ctl.sv
// Directed self-checking bench for spy_ctl: register map, snapshot coherence,
// run/halt/step sequencing, error latch and reset behaviour.
module tb_spy_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbread, dbwrite;
  logic [3:0]  eadr;
  logic [15:0] spy_out, spy_in;
  logic [47:0] cpu_ir;
  logic [13:0] cpu_pc;
  logic        cpu_ready, cpu_err;
  logic        cpu_run, cpu_step;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned step_pulses  = 0;
  int unsigned step_viol    = 0;
  logic        prev_step    = 1'b0;
  int unsigned base;

  spy_ctl #(
    .PC_W   (14),
    .STEP_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dbread    (dbread),
    .dbwrite   (dbwrite),
    .eadr      (eadr),
    .spy_out   (spy_out),
    .spy_in    (spy_in),
    .cpu_ir    (cpu_ir),
    .cpu_pc    (cpu_pc),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .cpu_run   (cpu_run),
    .cpu_step  (cpu_step)
  );

  always #5 clk = ~clk;

  // Sampled just before each rising edge, after inputs settle.
  always @(negedge clk) begin
    #4;
    if (cpu_step) begin
      step_pulses++;
      if (!cpu_ready || cpu_run || prev_step) step_viol++;
    end
    prev_step = cpu_step;
  end

  task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic spy_wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    dbwrite = 1'b1; eadr = a; spy_out = d;
    @(negedge clk);
    dbwrite = 1'b0;
  endtask

  task automatic spy_rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
    @(negedge clk);
    dbread = 1'b1; eadr = a;
    #1 chk(tag, 48'(spy_in), 48'(exp));
    @(negedge clk);
    dbread = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; dbread = 1'b0; dbwrite = 1'b0; eadr = '0; spy_out = '0;
    cpu_ir = '0; cpu_pc = '0; cpu_ready = 1'b0; cpu_err = 1'b0;
    idle(3);
    #1 chk("rst_run", 48'(cpu_run), 48'(0));
    chk("rst_step", 48'(cpu_step), 48'(0));
    reset = 1'b0;

    spy_rd("stepcnt_rst", 4'd7, 16'h0001);
    spy_rd("mode_rst", 4'd3, 16'h0000);
    spy_rd("status_rst", 4'd5, 16'h0000);

    spy_wr(4'd6, 16'hA5C3);
    spy_rd("scratch", 4'd6, 16'hA5C3);
    spy_rd("unmapped_rd", 4'd9, 16'h0000);
    spy_wr(4'd9, 16'hFFFF);
    spy_rd("wr9_scratch", 4'd6, 16'hA5C3);
    spy_rd("wr9_stepcnt", 4'd7, 16'h0001);
    spy_rd("wr9_mode", 4'd3, 16'h0000);

    // Simultaneous read and write returns pre-write data.
    @(negedge clk);
    dbread = 1'b1; dbwrite = 1'b1; eadr = 4'd6; spy_out = 16'h1111;
    #1 chk("rw_same", 48'(spy_in), 48'hA5C3);
    @(negedge clk);
    dbread = 1'b0; dbwrite = 1'b0;
    spy_rd("rw_after", 4'd6, 16'h1111);

    spy_wr(4'd3, 16'hFFF0);
    spy_rd("mode_upper", 4'd3, 16'hFFF0);
    spy_wr(4'd3, 16'h0000);

    cpu_ir = 48'h1234_5678_9ABC; cpu_pc = 14'h0123;
    spy_rd("ir0", 4'd0, 16'h9ABC);
    cpu_ir = 48'hDEAD_BEEF_CAFE; cpu_pc = 14'h3FFF;
    spy_rd("ir1", 4'd1, 16'h5678);
    spy_rd("ir2", 4'd2, 16'h1234);
    spy_rd("pc", 4'd4, 16'h0123);

    // Three steps with cpu_ready toggling.
    spy_wr(4'd7, 16'd3);
    base = step_pulses;
    spy_wr(4'd3, 16'h0002);
    for (int unsigned i = 0; i < 30; i++) begin
      @(negedge clk);
      cpu_ready = i[0];
    end
    chk("step3_count", 48'(step_pulses - base), 48'd3);
    cpu_ready = 1'b1;
    spy_rd("step3_mode", 4'd3, 16'h0000);
    spy_rd("step3_status", 4'd5, 16'h0008);

    spy_wr(4'd3, 16'h0001);
    #1 chk("run_on", 48'(cpu_run), 48'(1));
    spy_rd("run_status", 4'd5, 16'h0009);
    @(negedge clk); cpu_err = 1'b1;
    @(negedge clk); cpu_err = 1'b0;
    #1 chk("err_halt", 48'(cpu_run), 48'(0));
    spy_rd("err_status", 4'd5, 16'h000C);
    spy_rd("err_mode", 4'd3, 16'h0000);
    spy_wr(4'd5, 16'h0004);
    spy_rd("err_clr", 4'd5, 16'h0008);

    spy_wr(4'd7, 16'd0);
    base = step_pulses;
    spy_wr(4'd3, 16'h0002);
    idle(10);
    chk("step0_count", 48'(step_pulses - base), 48'd1);
    spy_rd("step0_mode", 4'd3, 16'h0000);

    // Abort a 5-step sequence by switching to run.
    spy_wr(4'd7, 16'd5);
    spy_wr(4'd3, 16'h0002);
    spy_wr(4'd3, 16'h0001);
    base = step_pulses;
    idle(10);
    chk("abort_steps", 48'(step_pulses - base), 48'd0);
    #1 chk("abort_run", 48'(cpu_run), 48'(1));
    spy_wr(4'd3, 16'h0000);
    #1 chk("halt_run", 48'(cpu_run), 48'(0));

    // Reset mid-step.
    spy_wr(4'd3, 16'h0002);
    spy_rd("mid_status", 4'd5, 16'h000A);
    @(negedge clk);
    dbread = 1'b1; eadr = 4'd7;
    #2 reset = 1'b1;
    #1 chk("rst_mid_run", 48'(cpu_run), 48'(0));
    chk("rst_mid_step", 48'(cpu_step), 48'(0));
    chk("rst_mid_spy", 48'(spy_in), 48'(0));
    @(negedge clk);
    dbread = 1'b0;
    reset = 1'b0;
    spy_rd("rst_stepcnt", 4'd7, 16'h0001);
    spy_rd("rst_mode", 4'd3, 16'h0000);
    spy_rd("rst_scratch", 4'd6, 16'h0000);
    spy_rd("rst_pc", 4'd4, 16'h0000);
    idle(4);
    chk("step_rules", 48'(step_viol), 48'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
